// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - Received-byte interface between uart_rx and its consumer (UART_RX_PARITY_EN adds o_parity_err)
interface uart_rx_if #(
  parameter int NB_DATA = 8
);

  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic               o_parity_err;
`endif

  // The receiver drives the byte and its status flags.
  modport master (
    output o_data,
    output o_rx_done,
    output o_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output o_parity_err
`endif
  );

  // The downstream FIFO / command interface only observes.
  modport slave (
    input o_data,
    input o_rx_done,
    input o_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    input o_parity_err
`endif
  );

endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - Oversampled UART receiver, mid-bit sampling; optional parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int NB_DATA      = 8,
  parameter int OVERSAMPLING = 16,
  parameter int SB_TICK      = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic      clk,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);

  // The tick counter serves both the bit period and the stop-bit wait.
  localparam int S_MAX = (OVERSAMPLING > SB_TICK) ? OVERSAMPLING : SB_TICK;
  localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLING - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);
`endif

  // Synchroniser and edge-detect history; all idle high.
  logic sync1_q;
  logic rx_s_q;
  logic rx_prev_q;

  logic [2:0]         state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [NW-1:0]      n_q, n_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic               parity_bad_q, parity_bad_d;
  logic               parity_err_q, parity_err_d;
`else
  logic               unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // Only a high-to-low transition starts a frame, so a held-low break
  // line cannot retrigger until it has gone high again.
  logic start_edge;
  assign start_edge = rx_prev_q & ~rx_s_q;

  // Bring the asynchronous line into the clk domain and keep one clk of history.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM: counts ticks to the middle of each bit and samples there.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shift_d     = shift_q;
    data_d      = data_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (s_q == S_HALF) begin
            s_d = '0;
            if (!rx_s_q) begin
              state_d = ST_DATA;
              n_d     = '0;
            end else begin
              // Line was high again at mid-start: a glitch, drop it silently.
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            shift_d = {rx_s_q, shift_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d          = '0;
            parity_bad_d = rx_s_q ^ (^shift_q) ^ PAR_ODD;
            state_d      = ST_STOP;
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_tick) begin
          if (s_q == S_STOP) begin
            // Leave at mid-stop so a start edge right after the stop bit is seen.
            s_d         = '0;
            state_d     = ST_IDLE;
            data_d      = shift_q;
            frame_err_d = ~rx_s_q;
            done_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = parity_bad_q;
`endif
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
    endcase
  end

  // Frame state, counters, shift register and the presented result.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_rx_done   = done_q;
  assign rx_if.o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - Randomized self-checking bench for uart_rx against a frame-level reference queue
module tb_uart_rx;

  localparam int NB_DATA    = 8;
  localparam int OVS        = 16;
  localparam int SB_TICK    = 16;
  localparam int PARITY_ODD = 0;
  localparam int TICK_CLK   = 4;
  localparam int BIT_CLK    = OVS * TICK_CLK;

  logic clk     = 1'b0;
  logic i_reset = 1'b0;
  logic i_tick  = 1'b0;
  logic i_rx    = 1'b1;

  uart_rx_if #(.NB_DATA(NB_DATA)) rx_if ();

  uart_rx #(
    .NB_DATA     (NB_DATA),
    .OVERSAMPLING(OVS),
    .SB_TICK     (SB_TICK),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .i_tick (i_tick),
    .i_rx   (i_rx),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB_DATA-1:0] data;
    logic               ferr;
    logic               perr;
  } frame_t;

  frame_t exp_q[$];
  frame_t got_f;
  int n_checks       = 0;
  int n_errors       = 0;
  int done_cnt       = 0;
  int tick_total     = 0;
  int last_done_tick = 0;
  int prev_done_tick = 0;
  logic done_prev    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-clk tick every TICK_CLK clocks.
  initial begin
    forever begin
      repeat (TICK_CLK - 1) @(posedge clk);
      #1 i_tick = 1'b1;
      @(posedge clk);
      #1 i_tick = 1'b0;
    end
  end

  // Every done pulse must match the oldest frame the sender queued.
  always @(negedge clk) begin
    if (i_tick) tick_total++;
    if (rx_if.o_rx_done) begin
      done_cnt++;
      prev_done_tick = last_done_tick;
      last_done_tick = tick_total;
      check("done_width", {31'd0, done_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        got_f = exp_q.pop_front();
        check("data", {24'd0, rx_if.o_data}, {24'd0, got_f.data});
        check("frame_err", {31'd0, rx_if.o_frame_err}, {31'd0, got_f.ferr});
`ifdef UART_RX_PARITY_EN
        check("parity_err", {31'd0, rx_if.o_parity_err}, {31'd0, got_f.perr});
`endif
      end
    end
    done_prev = rx_if.o_rx_done;
  end

  function automatic logic good_par(input logic [NB_DATA-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  task automatic push_exp(input logic [NB_DATA-1:0] d, input logic stop, input logic par);
    frame_t f;
    f.data = d;
    f.ferr = ~stop;
    f.perr = (par != good_par(d));
    exp_q.push_back(f);
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1 i_rx = b;
    repeat (BIT_CLK - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [NB_DATA-1:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < NB_DATA; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par !== 1'bx) begin end
`endif
    drive_bit(stop);
  endtask

  task automatic idle(input int nclk);
    @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (nclk) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic tx(input logic [NB_DATA-1:0] d, input logic stop, input logic par);
    push_exp(d, stop, par);
    send_frame(d, stop, par);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [NB_DATA-1:0] rd;
    logic rs, rp;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'd0, rx_if.o_data}, 32'd0);
    check("rst_done", {31'd0, rx_if.o_rx_done}, 32'd0);
    check("rst_ferr", {31'd0, rx_if.o_frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", {31'd0, rx_if.o_parity_err}, 32'd0);
`endif
    @(posedge clk);
    #1 i_reset = 1'b1;
    idle(100);

    // Single clean frame.
    tx(8'hA5, 1'b1, good_par(8'hA5));
    idle(20);
    drain();
    check("a5_count", done_cnt, 32'd1);

    // Short low glitch from idle is rejected and does not disturb o_data.
    c = done_cnt;
    @(posedge clk);
    #1 i_rx = 1'b0;
    repeat (4 * TICK_CLK) @(posedge clk);
    idle(300);
    check("glitch_count", done_cnt, c);
    check("glitch_data", {24'd0, rx_if.o_data}, 32'h0000_00A5);

    // Framing error then a clean frame clears it.
    tx(8'h3C, 1'b0, good_par(8'h3C));
    idle(BIT_CLK);
    drain();
    tx(8'h3C, 1'b1, good_par(8'h3C));
    idle(20);
    drain();

    // Back-to-back frames one frame period apart.
    tx(8'h00, 1'b1, good_par(8'h00));
    tx(8'hFF, 1'b1, good_par(8'hFF));
    idle(20);
    drain();
    check("b2b_spacing", last_done_tick - prev_done_tick, 32'd160);

    // Reset during data bit 3 of 0x81.
    c = done_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    @(posedge clk);
    #1 i_rx = 1'b0;
    repeat (BIT_CLK / 2) @(posedge clk);
    #1 i_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_data", {24'd0, rx_if.o_data}, 32'd0);
    check("mid_rst_ferr", {31'd0, rx_if.o_frame_err}, 32'd0);
    check("mid_rst_done", {31'd0, rx_if.o_rx_done}, 32'd0);
    @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_reset = 1'b1;
    idle(12 * BIT_CLK);
    check("mid_rst_count", done_cnt, c);
    tx(8'h55, 1'b1, good_par(8'h55));
    idle(20);
    drain();

`ifdef UART_RX_PARITY_EN
    tx(8'h07, 1'b1, 1'b1);
    idle(20);
    drain();
    tx(8'h07, 1'b1, 1'b0);
    idle(20);
    drain();
`endif

    // Break: exactly one all-zero frame with a framing error.
    c = done_cnt;
    push_exp('0, 1'b0, 1'b0);
    @(posedge clk);
    #1 i_rx = 1'b0;
    repeat (15 * BIT_CLK) @(posedge clk);
    idle(2 * BIT_CLK);
    drain();
    check("break_count", done_cnt, c + 1);

    // Randomized frames with random gaps and occasional bad stop/parity bits.
    c = done_cnt;
    for (int k = 0; k < 20; k++) begin
      rd = NB_DATA'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rp = good_par(rd) ^ ($urandom_range(0, 3) == 0);
      tx(rd, rs, rp);
      if (!rs) idle(BIT_CLK + $urandom_range(0, 40));
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 80));
    end
    idle(20);
    drain();
    check("rand_count", done_cnt, c + 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver that consumes the 16x oversampling tick from the team's baud-rate generator and deserialises the asynchronous i_rx line into parallel bytes.
- Frame format: 1 start bit, NB_DATA data bits LSB first, optional parity bit (see Optional Feature), 1 stop bit.
- Sits between the pin-level RX input and the downstream byte consumer (FIFO / command interface); presents a one-clock done pulse per received frame.

Parameters:
- NB_DATA, 8, number of data bits per frame.
- OVERSAMPLING, 16, i_tick pulses per bit period; must be even, ≥4.
- SB_TICK, 16, ticks counted in STOP state before sampling the stop bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored unless UART_RX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock.
- i_reset  input  1  asynchronous, active-low reset.
- i_tick  input  1  one-clk sampling strobe, OVERSAMPLING per bit period.
- i_rx  input  1  raw serial line, idle high, asynchronous to clk.
- o_data  output  NB_DATA  last received data word.
- o_rx_done  output  1  one-clk pulse when a frame completes.
- o_frame_err  output  1  stop-bit value of last frame was 0.
- o_parity_err  output  1  present only with UART_RX_PARITY_EN.

Behaviour:
- Reset values: synchroniser flops = 1; state = IDLE; tick counter s = 0; bit counter n = 0; shift register, o_data, o_rx_done, o_frame_err, o_parity_err = 0.
- i_rx passes through a 2-flop synchroniser; rx_s is the synchronised value, rx_prev its one-clk delay (reset 1).
- IDLE: falling edge (rx_prev = 1, rx_s = 0) -> START, s = 0. Ignores i_tick. A held-low line (break) re-arms only after rx_s returns to 1.
- START: on i_tick: if s = OVERSAMPLING/2-1 then { rx_s = 0 -> DATA, s = 0, n = 0; rx_s = 1 -> IDLE (glitch reject, no done pulse) } else s++.
- DATA: on i_tick: if s = OVERSAMPLING-1 then shift rx_s into MSB of shift register (LSB first on wire), s = 0, and if n = NB_DATA-1 go to STOP (or PARITY), else n++. Otherwise s++.
- STOP: on i_tick: if s = SB_TICK-1 then o_data <= shift register, o_frame_err <= ~rx_s, o_rx_done = 1 for exactly one clk, state -> IDLE. Otherwise s++.
- Sampling is mid-bit: first sample is OVERSAMPLING/2 ticks after the start edge, then every OVERSAMPLING ticks.
- No i_tick: state, counters, and outputs hold indefinitely.
- o_data, o_frame_err, and o_parity_err hold until the next completed frame; they are never cleared by a glitch-rejected start.
- Back-to-back frames: return to IDLE at mid-stop, so a start edge directly after the stop bit is caught.
- Reset asserted mid-frame: immediate return to reset values, no o_rx_done. After release, the first falling edge starts a fresh frame.
- Break (line low over whole frame): one frame completes with o_data = 0 and o_frame_err = 1, then no further frames until the line goes high.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - PARITY samples rx_s at s = OVERSAMPLING-1.
  - Expected parity bit = XOR of data bits, XOR PARITY_ODD.
  - Mismatch is latched and presented on o_parity_err, updated together with o_data at the o_rx_done pulse.
  - o_parity_err resets to 0.
- Not defined: no PARITY state, no o_parity_err port, and the frame is start + NB_DATA + stop.

Test Plan:
- i_tick every 4 clk; send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> exactly one o_rx_done pulse, o_data = 0xA5, o_frame_err = 0.
- Low glitch lasting 4 ticks from idle -> state returns to IDLE, no o_rx_done; o_data keeps its prior value 0xA5.
- Send 0x3C with stop bit driven 0 -> o_rx_done pulse, o_data = 0x3C, o_frame_err = 1; next clean 0x3C -> o_frame_err = 0.
- Back-to-back 0x00 then 0xFF, no idle gap -> two o_rx_done pulses 160 ticks apart, o_data = 0x00 then 0xFF.
- Assert i_reset during data bit 3 of 0x81 -> all outputs 0, no done pulse; after release send 0x55 -> o_data = 0x55.
- With UART_RX_PARITY_EN and PARITY_ODD = 0, send 0x07 with parity bit 1 -> o_parity_err = 0. Same frame with parity bit 0 -> o_parity_err = 1, o_data = 0x07.
